// File: rtl/des_key_schedule.sv
// rtl/des_key_schedule.sv - sequential DES round-key generator (PC-1, C/D rotations, PC-2)
module des_key_schedule #(
    parameter int ROUNDS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [64:1] key,
    input  logic        decrypt,
    input  logic        next,
    output logic [48:1] subkey,
    output logic [4:0]  round,
    output logic        key_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Index n of every vector here is DES bit n (bit 1 = leftmost in the tables).
    localparam int PC1_TAB [56] = '{
        57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
        10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
        14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
    };

    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_q, state_d;
    logic [28:1] c_q, c_d;
    logic [28:1] d_q, d_d;
    logic [4:0]  round_q, round_d;
    logic        dir_q, dir_d;
    logic        done_q, done_d;

    logic [56:1] pc1_cd;
    logic [56:1] cd;
    logic [48:1] pc2_k;
    logic        last_key;
    logic        unused_parity;

    // Parity bits take no part in the schedule.
    assign unused_parity = ^{key[8], key[16], key[24], key[32],
                             key[40], key[48], key[56], key[64]};

    // Rotating toward index 1 is a DES left shift; index 1 wraps to index 28.
    function automatic logic [28:1] rotl(input logic [28:1] v, input logic two);
        return two ? {v[2:1], v[28:3]} : {v[1], v[28:2]};
    endfunction

    function automatic logic [28:1] rotr(input logic [28:1] v, input logic two);
        return two ? {v[26:1], v[28:27]} : {v[27:1], v[28]};
    endfunction

    function automatic logic shift_two(input logic [4:0] r);
        return !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
    endfunction

    always_comb begin
        pc1_cd = '0;
        for (int i = 0; i < 56; i++) begin
            pc1_cd[i+1] = key[PC1_TAB[i][6:0]];
        end
    end

    assign cd = {d_q, c_q};

    always_comb begin
        pc2_k = '0;
        for (int j = 0; j < 48; j++) begin
            pc2_k[j+1] = cd[PC2_TAB[j][5:0]];
        end
    end

    assign last_key = dir_q ? (round_q == 5'd1) : (round_q == 5'(ROUNDS));

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        d_d     = d_q;
        round_d = round_q;
        dir_d   = dir_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    dir_d   = decrypt;
                    // PC-1 output is already CD16 since the total shift is a full ring.
                    if (decrypt) begin
                        c_d     = pc1_cd[28:1];
                        d_d     = pc1_cd[56:29];
                        round_d = 5'(ROUNDS);
                    end else begin
                        c_d     = rotl(pc1_cd[28:1], 1'b0);
                        d_d     = rotl(pc1_cd[56:29], 1'b0);
                        round_d = 5'd1;
                    end
                end
            end
            RUN: begin
                if (next) begin
                    if (last_key) begin
                        state_d = IDLE;
                        round_d = 5'd0;
                        done_d  = 1'b1;
                    end else if (!dir_q) begin
                        c_d     = rotl(c_q, shift_two(round_q + 5'd1));
                        d_d     = rotl(d_q, shift_two(round_q + 5'd1));
                        round_d = round_q + 5'd1;
                    end else begin
                        c_d     = rotr(c_q, shift_two(round_q));
                        d_d     = rotr(d_q, shift_two(round_q));
                        round_d = round_q - 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            c_q     <= '0;
            d_q     <= '0;
            round_q <= '0;
            dir_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            d_q     <= d_d;
            round_q <= round_d;
            dir_q   <= dir_d;
            done_q  <= done_d;
        end
    end

    assign key_valid = (state_q == RUN);
    assign busy      = (state_q == RUN);
    assign round     = round_q;
    assign done      = done_q;
    assign subkey    = key_valid ? pc2_k : '0;

endmodule

// File: tb/tb_des_key_schedule.sv
// tb/tb_des_key_schedule.sv - scoreboard bench for des_key_schedule with known DES subkeys
module tb_des_key_schedule;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [64:1] key;
    logic        decrypt;
    logic        next;
    logic [48:1] subkey;
    logic [4:0]  round;
    logic        key_valid;
    logic        busy;
    logic        done;

    des_key_schedule dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .key      (key),
        .decrypt  (decrypt),
        .next     (next),
        .subkey   (subkey),
        .round    (round),
        .key_valid(key_valid),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  rnd;
        logic [48:1] k;
        bit          last;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    bit          done_exp = 1'b0;
    logic [48:1] kdes [1:16];
    logic [64:1] main_key;
    logic [64:1] other_key;

    // Hex constants are written DES-bit-1-first; remap so that index n is DES bit n.
    function automatic logic [48:1] rev48(input logic [47:0] h);
        logic [48:1] r;
        for (int n = 1; n <= 48; n++) r[n] = h[48-n];
        return r;
    endfunction

    function automatic logic [64:1] rev64(input logic [63:0] h);
        logic [64:1] r;
        for (int n = 1; n <= 64; n++) r[n] = h[64-n];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_run(input bit dec);
        exp_t e;
        for (int i = 1; i <= 16; i++) begin
            e.rnd  = dec ? 5'(17 - i) : 5'(i);
            e.k    = kdes[e.rnd];
            e.last = (i == 16);
            sb.push_back(e);
        end
    endtask

    task automatic chk_done_idle(input string name);
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_kv"}, 64'(key_valid), 64'd0);
        chk({name, "_round"}, 64'(round), 64'd0);
        chk({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Monitor: every consumed key (key_valid && next) is popped and compared.
    always @(negedge clk) begin
        exp_t e;
        bit   pend;
        pend = done_exp;
        done_exp = 1'b0;
        if (done || pend) chk("mon_done", 64'(done), 64'(pend));
        if (!rst && key_valid && next) begin
            if (sb.size() == 0) begin
                chk("mon_unexpected_key", 64'(round), 64'd0);
            end else begin
                e = sb.pop_front();
                chk("mon_round", 64'(round), 64'(e.rnd));
                chk("mon_subkey", 64'(subkey), 64'(e.k));
                if (e.last) done_exp = 1'b1;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [47:0] hex [1:16];
        hex[1]  = 48'h1B02EFFC7072; hex[2]  = 48'h79AED9DBC9E5;
        hex[3]  = 48'h55FC8A42CF99; hex[4]  = 48'h72ADD6DB351D;
        hex[5]  = 48'h7CEC07EB53A8; hex[6]  = 48'h63A53E507B2F;
        hex[7]  = 48'hEC84B7F618BC; hex[8]  = 48'hF78A3AC13BFB;
        hex[9]  = 48'hE0DBEBEDE781; hex[10] = 48'hB1F347BA464F;
        hex[11] = 48'h215FD3DED386; hex[12] = 48'h7571F59467E9;
        hex[13] = 48'h97C5D1FABA41; hex[14] = 48'h5F43B7F2E73A;
        hex[15] = 48'hBF918D3D3F0A; hex[16] = 48'hCB3D8B0E17F5;
        for (int i = 1; i <= 16; i++) kdes[i] = rev48(hex[i]);
        main_key  = rev64(64'h133457799BBCDFF1);
        other_key = rev64(64'h0123456789ABCDEF);

        rst = 1'b1; start = 1'b0; key = '0; decrypt = 1'b0; next = 1'b0;
        tick(); tick();
        chk("rst_subkey", 64'(subkey), 64'd0);
        chk("rst_round", 64'(round), 64'd0);
        chk("rst_kv", 64'(key_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        // Encrypt: first-key latency, single step, then run to the end.
        push_run(1'b0);
        start = 1'b1; key = main_key; decrypt = 1'b0;
        tick();
        start = 1'b0; key = other_key;
        chk("enc_k1_round", 64'(round), 64'd1);
        chk("enc_k1_kv", 64'(key_valid), 64'd1);
        chk("enc_k1_busy", 64'(busy), 64'd1);
        chk("enc_k1_subkey", 64'(subkey), 64'(kdes[1]));
        next = 1'b1; tick(); next = 1'b0;
        chk("enc_k2_round", 64'(round), 64'd2);
        chk("enc_k2_subkey", 64'(subkey), 64'(kdes[2]));
        next = 1'b1;
        repeat (14) tick();
        chk("enc_k16_round", 64'(round), 64'd16);
        chk("enc_k16_subkey", 64'(subkey), 64'(kdes[16]));
        tick(); next = 1'b0;
        chk_done_idle("enc_end");
        tick();
        chk("enc_done_pulse", 64'(done), 64'd0);

        // Decrypt: K16 first; key/decrypt changes after start have no effect.
        push_run(1'b1);
        start = 1'b1; key = main_key; decrypt = 1'b1;
        tick();
        start = 1'b0; key = other_key; decrypt = 1'b0;
        chk("dec_k16_round", 64'(round), 64'd16);
        chk("dec_k16_subkey", 64'(subkey), 64'(kdes[16]));
        next = 1'b1;
        repeat (15) tick();
        chk("dec_k1_round", 64'(round), 64'd1);
        chk("dec_k1_subkey", 64'(subkey), 64'(kdes[1]));
        tick(); next = 1'b0;
        chk_done_idle("dec_end");
        tick();

        // Back-to-back with starts while busy, including one on the final next.
        push_run(1'b0);
        start = 1'b1; key = main_key; decrypt = 1'b0;
        tick();
        start = 1'b0; next = 1'b1;
        repeat (4) tick();
        chk("b2b_round5", 64'(round), 64'd5);
        start = 1'b1; key = other_key; decrypt = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        start = 1'b1;
        tick();
        start = 1'b0; next = 1'b0;
        chk_done_idle("b2b_end");
        chk("b2b_no_gaps", 64'(sb.size()), 64'd0);

        // Start in the done cycle is accepted; stall at round 9.
        push_run(1'b0);
        start = 1'b1; key = main_key; decrypt = 1'b0;
        tick();
        start = 1'b0; key = other_key;
        chk("restart_round", 64'(round), 64'd1);
        next = 1'b1;
        repeat (8) tick();
        next = 1'b0;
        for (int s = 0; s < 10; s++) begin
            chk("stall_round", 64'(round), 64'd9);
            chk("stall_subkey", 64'(subkey), 64'(kdes[9]));
            tick();
        end
        next = 1'b1;
        tick();
        chk("stall_resume_round", 64'(round), 64'd10);
        chk("stall_resume_subkey", 64'(subkey), 64'(kdes[10]));
        repeat (7) tick();
        next = 1'b0;
        chk_done_idle("stall_end");
        tick();

        // Reset mid-schedule aborts silently; then start+next together in IDLE.
        push_run(1'b0);
        start = 1'b1; key = main_key; decrypt = 1'b0;
        tick();
        start = 1'b0; next = 1'b1;
        repeat (6) tick();
        next = 1'b0;
        chk("rstmid_round7", 64'(round), 64'd7);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        chk("rstmid_subkey", 64'(subkey), 64'd0);
        chk("rstmid_round", 64'(round), 64'd0);
        chk("rstmid_kv", 64'(key_valid), 64'd0);
        chk("rstmid_busy", 64'(busy), 64'd0);
        chk("rstmid_done", 64'(done), 64'd0);
        tick();
        chk("rstmid_done_after", 64'(done), 64'd0);
        push_run(1'b0);
        start = 1'b1; next = 1'b1; key = main_key;
        tick();
        start = 1'b0;
        chk("fresh_k1_round", 64'(round), 64'd1);
        chk("fresh_k1_subkey", 64'(subkey), 64'(kdes[1]));
        repeat (16) tick();
        next = 1'b0;
        chk_done_idle("fresh_end");
        tick(); tick();

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Sequential DES round-key generator for the iterative round datapath.
- Latches a 64-bit key once, applies PC-1, then produces one 48-bit subkey per round (C/D rotations, then PC-2).
- Each subkey is XORed with the 48-bit Expansion output in the round function.
- Supports forward order (K1..K16, encrypt) and reverse order (K16..K1, decrypt). The round controller paces it with a next pulse.

Parameters:
- ROUNDS, 16, number of subkeys per key load; fixed by DES, not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  load key and begin schedule; honoured only in IDLE
- key  input  [64:1]  DES key; key[n] = FIPS 46-3 bit n; parity bits 8,16,..,64 ignored
- decrypt  input  1  sampled with start; 1 = reverse order
- next  input  1  consumer has used current subkey; advance
- subkey  output  [48:1]  current round key; subkey[n] = DES subkey bit n
- round  output  [4:0]  1..16 = index of the key on subkey (K number); 0 when idle
- key_valid  output  1  subkey/round valid
- busy  output  1  schedule in progress (START..last round)
- done  output  1  one-cycle pulse after the final subkey is consumed

Behaviour:
- Bit numbering: index n is DES bit n throughout, same as the Expansion stage. Index 1 is the leftmost bit in the standard tables.
- State: C[28:1] and D[28:1] registers, 2-state FSM (IDLE, RUN), direction flag, round counter.
- Shift schedule s(i): 1 for i in {1,2,9,16}, 2 otherwise.
- Reset: all registers cleared. Outputs subkey=0, round=0, key_valid=0, busy=0, done=0, FSM=IDLE. Reset mid-schedule aborts with no done pulse.
- IDLE + start, with decrypt=0:
  - C,D <= rotl(PC-1(key), 1).
  - Next cycle: RUN, round=1, key_valid=1, busy=1.
- IDLE + start, with decrypt=1:
  - C,D <= PC-1(key), which equals CD16.
  - Next cycle: RUN, round=16.
- Latency: start to first valid subkey is 1 cycle.
- subkey = PC-2(C,D), derived combinationally from the registers only. It has no combinational path from any input and is 0 whenever key_valid=0.
- RUN + next, encrypt, round i<16: C,D <= rotl(C,D, s(i+1)); round <= i+1.
- RUN + next, decrypt, round i>1: C,D <= rotr(C,D, s(i)); round <= i-1.
- RUN + next on the last key (K16 when encrypting, K1 when decrypting):
  - FSM->IDLE; key_valid=0, busy=0, round=0.
  - done=1 for exactly that next cycle, then 0.
- next with key_valid=0: ignored.
- Holding next high advances one round per cycle. Sixteen consecutive next cycles deliver all keys back-to-back.
- start while busy: ignored, including start coinciding with the final next. start is re-accepted from the cycle after done.
- start and next asserted together in IDLE: next is ignored.
- key and decrypt are sampled only on an accepted start. Later changes have no effect.
- C and D rotate independently as 28-bit rings. Rotation of index 1 wraps to index 28.

Test Plan:
All hex values are written DES-bit-1-first (leftmost bit = index 1).
- Encrypt first key: rst, then start with key=133457799BBCDFF1, decrypt=0. Required: 1 cycle later round=1, key_valid=1, subkey=1B02EFFC7072.
- Encrypt progression: from the above, pulse next once. Required: round=2, subkey=79AED9DBC9E5. Hold next 14 more cycles; required: round=16, subkey=CB3D8B0E17F5.
- Decrypt order: start with the same key, decrypt=1. Required: round=16, subkey=CB3D8B0E17F5. Then next holds 15 cycles; required: round=1, subkey=1B02EFFC7072. Next again; required: done pulses 1 cycle, key_valid=0, round=0.
- Back-to-back and ignored start: next held high continuously yields 16 distinct keys in 16 cycles with no gaps. Assert start with a different key at round=5; required: sequence unchanged.
- Stalls: deassert next for 10 cycles at round=9. Required: subkey and round stable throughout, resuming at round=10 with the correct key.
- Reset mid-operation: rst at round=7. Required: next cycle all outputs 0 with no done pulse. A fresh start then produces K1=1B02EFFC7072 correctly.
